// File: rtl/rvx10_pipe_pkg.sv
// rvx10_pipe_pkg: shared stage/control-case types and the hazard priority decode.
package rvx10_pipe_pkg;
  localparam int CNT_W_DEF = 32;
  typedef enum logic [2:0] {S_F, S_D, S_E, S_M, S_W} stage_e;
  typedef enum logic [2:0] {C_RUN, C_BUBBLE_E, C_LOADUSE, C_REDIRECT, C_FREEZE} ctrl_case_e;
  function automatic ctrl_case_e decode_case(logic busy, logic pcsrc, logic stall, logic flush);
    return busy ? C_FREEZE : pcsrc ? C_REDIRECT : stall ? C_LOADUSE : flush ? C_BUBBLE_E : C_RUN;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its maximum instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else if (inc && count_q != '1) count_q <= count_q + 1'b1;
  assign count = count_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: turns hazard requests into stage enables/flushes, tracks stage
// validity and counts stall cycles, injected bubbles and retired instructions.
module pipe_stall_ctrl
  import rvx10_pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallReqD,
  input  logic             FlushReqE,
  input  logic             PCSrcE,
  input  logic             DMemBusyM,
  input  logic             IMemValidF,
  output logic             EnF,
  output logic             EnD,
  output logic             EnE,
  output logic             EnM,
  output logic             EnW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ValidD,
  output logic             ValidE,
  output logic             ValidM,
  output logic             ValidW,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] BubbleCnt,
  output logic [CNT_W-1:0] RetireCnt
);
  ctrl_case_e c;
  logic [4:1] valid_q, valid_d;
  logic       front_en;
  assign c        = decode_case(DMemBusyM, PCSrcE, StallReqD, FlushReqE);
  assign front_en = c == C_RUN || c == C_BUBBLE_E || c == C_REDIRECT;
  assign EnF      = !reset && front_en;
  assign EnD      = !reset && front_en;
  assign EnE      = !reset && c != C_FREEZE;
  assign EnM      = !reset && c != C_FREEZE;
  assign EnW      = !reset && c != C_FREEZE;
  assign FlushD   = !reset && c == C_REDIRECT;
  assign FlushE   = !reset && (c == C_REDIRECT || c == C_LOADUSE || c == C_BUBBLE_E);
  always_comb begin
    valid_d       = '0;
    valid_d[S_D]  = c == C_REDIRECT ? 1'b0 : c == C_LOADUSE ? valid_q[S_D] : IMemValidF;
    valid_d[S_E]  = c == C_RUN ? valid_q[S_D] : 1'b0;
    valid_d[S_M]  = valid_q[S_E];
    valid_d[S_W]  = valid_q[S_M];
  end
  // A freeze holds every stage, so the valid chain simply does not shift.
  always_ff @(posedge clk or posedge reset)
    if (reset) valid_q <= '0;
    else if (c != C_FREEZE) valid_q <= valid_d;
  assign ValidD = valid_q[S_D];
  assign ValidE = valid_q[S_E];
  assign ValidM = valid_q[S_M];
  assign ValidW = valid_q[S_W];
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(c == C_LOADUSE || c == C_FREEZE), .count(StallCnt)
  );
  sat_counter #(.W(CNT_W)) u_bubble (
    .clk(clk), .reset(reset), .inc(FlushE), .count(BubbleCnt)
  );
  sat_counter #(.W(CNT_W)) u_retire (
    .clk(clk), .reset(reset), .inc(valid_q[S_W] && c != C_FREEZE), .count(RetireCnt)
  );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of enables, valid chain and counters.
module tb_pipe_stall_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic StallReqD = 0, FlushReqE = 0, PCSrcE = 0, DMemBusyM = 0, IMemValidF = 0;
  logic EnF, EnD, EnE, EnM, EnW, FlushD, FlushE, ValidD, ValidE, ValidM, ValidW;
  logic [31:0] StallCnt, BubbleCnt, RetireCnt;
  logic s_EnF, s_EnD, s_EnE, s_EnM, s_EnW, s_FlushD, s_FlushE, s_VD, s_VE, s_VM, s_VW;
  logic [3:0] s_Stall, s_Bubble, s_Retire;
  int errors = 0, checks = 0;
  int e_stall = 0, e_bub = 0, e_ret = 0;
  always #5 clk = ~clk;
  pipe_stall_ctrl dut (
    .clk(clk), .reset(reset), .StallReqD(StallReqD), .FlushReqE(FlushReqE), .PCSrcE(PCSrcE),
    .DMemBusyM(DMemBusyM), .IMemValidF(IMemValidF), .EnF(EnF), .EnD(EnD), .EnE(EnE), .EnM(EnM),
    .EnW(EnW), .FlushD(FlushD), .FlushE(FlushE), .ValidD(ValidD), .ValidE(ValidE),
    .ValidM(ValidM), .ValidW(ValidW), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt),
    .RetireCnt(RetireCnt)
  );
  pipe_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .StallReqD(StallReqD), .FlushReqE(FlushReqE), .PCSrcE(PCSrcE),
    .DMemBusyM(DMemBusyM), .IMemValidF(IMemValidF), .EnF(s_EnF), .EnD(s_EnD), .EnE(s_EnE),
    .EnM(s_EnM), .EnW(s_EnW), .FlushD(s_FlushD), .FlushE(s_FlushE), .ValidD(s_VD),
    .ValidE(s_VE), .ValidM(s_VM), .ValidW(s_VW), .StallCnt(s_Stall), .BubbleCnt(s_Bubble),
    .RetireCnt(s_Retire)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic s, input logic f, input logic p, input logic b, input logic v);
    StallReqD = s; FlushReqE = f; PCSrcE = p; DMemBusyM = b; IMemValidF = v;
    #1;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [6:0] ens();
    return {EnF, EnD, EnE, EnM, EnW, FlushD, FlushE};
  endfunction
  function automatic logic [3:0] vld();
    return {ValidD, ValidE, ValidM, ValidW};
  endfunction
  task automatic cnts(input string tag);
    chk({tag, "_stall"}, StallCnt, e_stall);
    chk({tag, "_bubble"}, BubbleCnt, e_bub);
    chk({tag, "_retire"}, RetireCnt, e_ret);
  endtask
  logic [3:0] run_v [7] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
  logic [3:0] alt_v [8] = '{4'b1000, 4'b0100, 4'b1010, 4'b0101, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
  logic [3:0] lu_v [5]  = '{4'b1011, 4'b1101, 4'b1110, 4'b1111, 4'b1111};
  int lu_r [5] = '{4, 5, 6, 6, 7};
  initial begin
    #1;
    chk("rst_en", ens(), 7'b0);
    chk("rst_valid", vld(), 4'b0);
    cnts("rst");
    drive(0, 0, 0, 0, 1);
    chk("rst_en_busyreq", ens(), 7'b0);
    #10 reset = 1'b0;
    #1;
    chk("run_en", ens(), 7'b1111100);
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk($sformatf("run_valid%0d", k + 1), vld(), run_v[k]);
      if (k == 5) begin e_ret = 2; cnts("run6"); end
    end
    e_ret = 3;
    chk("run7_retire", RetireCnt, e_ret);
    drive(1, 1, 0, 0, 1);
    chk("lu_en", ens(), 7'b0011101);
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 0) begin drive(0, 0, 0, 0, 1); e_stall = 1; e_bub = 1; end
      e_ret = lu_r[k];
      chk($sformatf("lu_valid%0d", k), vld(), lu_v[k]);
      cnts($sformatf("lu%0d", k));
    end
    drive(1, 0, 1, 0, 1);
    chk("redir_en", ens(), 7'b1111111);
    cyc();
    e_bub = 2; e_ret = 8;
    chk("redir_valid", vld(), 4'b0011);
    cnts("redir");
    drive(1, 0, 1, 1, 1);
    chk("frz_en", ens(), 7'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("frz_valid%0d", k), vld(), 4'b0011);
    end
    e_stall = 4;
    cnts("frz");
    drive(1, 0, 1, 0, 1);
    chk("unfrz_en", ens(), 7'b1111111);
    cyc();
    e_bub = 3; e_ret = 9;
    chk("unfrz_valid", vld(), 4'b0001);
    cnts("unfrz");
    drive(0, 0, 0, 0, 0);
    cyc();
    e_ret = 10;
    chk("drain_valid", vld(), 4'b0000);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, k < 4 ? ~k[0] : 1'b0);
      cyc();
      chk($sformatf("alt_valid%0d", k), vld(), alt_v[k]);
    end
    e_ret = 12;
    cnts("alt");
    drive(0, 0, 0, 1, 1);
    for (int k = 0; k < 20; k++) cyc();
    e_stall = 24;
    cnts("sat20");
    chk("sat4_stall", {28'b0, s_Stall}, 15);
    chk("sat4_retire", {28'b0, s_Retire}, 12);
    chk("sat4_bubble", {28'b0, s_Bubble}, 3);
    cyc();
    e_stall = 25;
    chk("sat21_stall", StallCnt, e_stall);
    chk("sat4_hold", {28'b0, s_Stall}, 15);
    drive(0, 0, 0, 0, 1);
    cyc();
    cyc();
    chk("pre_rst_valid", vld(), 4'b1100);
    #2 reset = 1'b1;
    #1;
    e_stall = 0; e_bub = 0; e_ret = 0;
    chk("arst_valid", vld(), 4'b0);
    chk("arst_en", ens(), 7'b0);
    cnts("arst");
    chk("arst_sat4", {28'b0, s_Stall}, 0);
    cyc();
    chk("arst_hold_valid", vld(), 4'b0);
    chk("arst_hold_en", ens(), 7'b0);
    #2 reset = 1'b0;
    cyc();
    chk("post_rst_valid", vld(), 4'b1000);
    cnts("post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
